cf_sync_receiver: RTL

//   Clocked receiving end of the self-timed CF pipeline: terminates the 4-phase

---
 rtl/cf_sync_receiver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cf_sync_receiver.sv
// rtl/cf_sync_receiver.sv - clocked receiving end of the self-timed CF pipeline
//
// Purpose:
//   Terminates the 4-phase bundled-data handshake (Send_in/Ack_out) from the
//   last CF stage. Send_in is synchronised, Data_in is captured into a
//   show-ahead FIFO, and the words leave as a clocked valid/ready stream.
//   A full FIFO withholds Ack_out, which stalls the asynchronous pipeline.
//
// Ports:
//   CLK        in   1      clock, all state on the rising edge
//   MR_n       in   1      master reset, asynchronous, active-low
//   Send_in    in   1      4-phase return-to-zero request from upstream
//   Data_in    in   W      bundled data, stable while Send_in is high
//   Ack_out    out  1      registered acknowledge to upstream
//   Out_valid  out  1      Out_data holds a valid word (FIFO not empty)
//   Out_ready  in   1      consumer takes the head word when Out_valid is high
//   Out_data   out  W      FIFO head word (show-ahead)
//   Level      out  AW+1   FIFO occupancy, 0..DEPTH
//   Overrun    out  1      sticky: a request was withdrawn before it was acked
module cf_sync_receiver #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int SYNC  = 2
) (
  input  logic                       CLK,
  input  logic                       MR_n,
  input  logic                       Send_in,
  input  logic [W-1:0]               Data_in,
  output logic                       Ack_out,
  output logic                       Out_valid,
  input  logic                       Out_ready,
  output logic [W-1:0]               Out_data,
  output logic [$clog2(DEPTH):0]     Level,
  output logic                       Overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [SYNC-1:0] sync_q;
  logic            req_s;
  logic            req_early;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;

  logic            full;
  logic            wr_en;
  logic            rd_en;

  logic            blocked_q;
  logic            blocked_d;
  logic            overrun_q;
  logic            overrun_d;

  // Synchroniser chain; stage 0 samples the asynchronous request.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], Send_in};
    end
  end

  assign req_s = sync_q[SYNC-1];
  // The release of an acknowledged request is taken one stage early so that
  // Ack_out falls SYNC edges after Send_in. By the time IDLE is re-entered the
  // last stage has also dropped, so the same request cannot be written twice.
  assign req_early = sync_q[SYNC-2];

  assign full      = (level_q == LEVEL_FULL);
  assign Out_valid = (level_q != '0);
  assign rd_en     = Out_valid & Out_ready;

  // FSM state register.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, FIFO write strobe and protocol-violation tracking.
  // The full decision uses the registered level only, so a read in the same
  // cycle never lets a write through at Level==DEPTH.
  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    blocked_d = blocked_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          if (!full) begin
            wr_en     = 1'b1;
            state_d   = ACK;
            blocked_d = 1'b0;
          end else begin
            blocked_d = 1'b1;
          end
        end else if (blocked_q) begin
          // Request withdrawn while it was still being held off.
          overrun_d = 1'b1;
          blocked_d = 1'b0;
        end
      end
      ACK: begin
        if (!req_early) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage and pointers; DEPTH is a power of two so pointers wrap
  // naturally.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= Data_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      blocked_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      blocked_q <= blocked_d;
      overrun_q <= overrun_d;
    end
  end

  assign Ack_out  = (state_q == ACK);
  assign Out_data = mem_q[rd_ptr_q];
  assign Level    = level_q;
  assign Overrun  = overrun_q;

endmodule
